sprite_fetch_scheduler: RTL and testbench

SPRITE_FETCH_SCHEDULER -- requirements
Module: sprite_fetch_scheduler

---
 rtl/sprite_fetch_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_sprite_fetch_scheduler.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_fetch_scheduler.sv
// -----------------------------------------------------------------------------
// sprite_fetch_scheduler
//
// Purpose:
//   For each video line, works out which sprite slots cover the next line
//   (y+1), fetches the matching sprite row from memory one word at a time and
//   strobes it into the owning slot's line buffer. Slots are scanned in index
//   order, one slot per cycle. A hit costs one memory handshake plus a
//   one-cycle load strobe.
//
// Ports:
//   pixel_clock       sole clock, rising edge
//   reset_n           synchronous active-low reset
//   hsync_start       one-cycle line-start pulse; starts a scan when idle
//   vsync_start       one-cycle frame-start pulse; cuts a scan short
//   y                 current line number (signed)
//   sprite_enable     per-slot enable
//   sprite_y          per-slot top line (signed), slot i at [i*COORD_WIDTH +: COORD_WIDTH]
//   sprite_base_addr  per-slot address of row 0, packed like sprite_y
//   mem_req           read request, held until mem_ack
//   mem_addr          read address, stable while mem_req is high
//   mem_ack           one-cycle acknowledge, mem_rdata valid with it
//   mem_rdata         read data
//   line_data         fetched sprite row for the slot being loaded
//   line_load         one-hot, one-cycle load strobe per slot
//   busy              high whenever the scheduler is not idle
//   line_done         one-cycle pulse when a scan completes
//   overrun           one-cycle pulse when an hsync_start was dropped
// -----------------------------------------------------------------------------
module sprite_fetch_scheduler #(
   parameter int COORD_WIDTH   = 16,
   parameter int NUM_SPRITES   = 4,
   parameter int ADDR_WIDTH    = 16,
   parameter int DATA_WIDTH    = 16,
   parameter int SPRITE_HEIGHT = 16
) (
   input  logic                              pixel_clock,
   input  logic                              reset_n,
   input  logic                              hsync_start,
   input  logic                              vsync_start,
   input  logic [COORD_WIDTH-1:0]            y,
   input  logic [NUM_SPRITES-1:0]            sprite_enable,
   input  logic [NUM_SPRITES*COORD_WIDTH-1:0] sprite_y,
   input  logic [NUM_SPRITES*ADDR_WIDTH-1:0]  sprite_base_addr,
   output logic                              mem_req,
   output logic [ADDR_WIDTH-1:0]             mem_addr,
   input  logic                              mem_ack,
   input  logic [DATA_WIDTH-1:0]             mem_rdata,
   output logic [DATA_WIDTH-1:0]             line_data,
   output logic [NUM_SPRITES-1:0]            line_load,
   output logic                              busy,
   output logic                              line_done,
   output logic                              overrun
);

   localparam int IDX_W  = (NUM_SPRITES > 1)   ? $clog2(NUM_SPRITES)   : 1;
   localparam int ROW_W  = (SPRITE_HEIGHT > 1) ? $clog2(SPRITE_HEIGHT) : 1;
   // Target carries one extra bit so y+1 never wraps; the difference needs
   // one more so that target - sprite_y cannot overflow either.
   localparam int TGT_W  = COORD_WIDTH + 1;
   localparam int DIFF_W = COORD_WIDTH + 2;

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      REQUEST,
      LOAD,
      DONE
   } state_t;

   state_t             state;
   logic [IDX_W-1:0]   idx;
   logic [TGT_W-1:0]   target;
   logic               abort;   // vsync seen while a request was outstanding

   // Live view of the slot currently being evaluated.
   logic [COORD_WIDTH-1:0] cur_y;
   logic [ADDR_WIDTH-1:0]  cur_base;
   logic [DIFF_W-1:0]      diff;
   logic [ADDR_WIDTH-1:0]  row;
   logic                   hit;
   logic                   last_idx;

   assign cur_y    = sprite_y[idx*COORD_WIDTH +: COORD_WIDTH];
   assign cur_base = sprite_base_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];

   // Both operands sign-extended to DIFF_W, so diff is exact two's complement.
   assign diff = {target[TGT_W-1], target}
               - {{2{cur_y[COORD_WIDTH-1]}}, cur_y};

   // Non-negative and below the sprite height: the line lies inside the sprite.
   assign hit = sprite_enable[idx]
              && !diff[DIFF_W-1]
              && (diff < DIFF_W'(SPRITE_HEIGHT));

   // On a hit diff is in [0, SPRITE_HEIGHT), so its low bits are the row.
   assign row      = ADDR_WIDTH'(diff[ROW_W-1:0]);
   assign last_idx = (idx == IDX_W'(NUM_SPRITES - 1));

   // NOTE: every register, including the output strobes, is assigned with
   // non-blocking assignments in this one clocked block so that all of them
   // see the same pre-edge values of state, idx and target.
   always_ff @(posedge pixel_clock) begin
      if (!reset_n) begin
         state     <= IDLE;
         idx       <= '0;
         target    <= '0;
         abort     <= 1'b0;
         mem_req   <= 1'b0;
         mem_addr  <= '0;
         line_data <= '0;
         line_load <= '0;
         busy      <= 1'b0;
         line_done <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         // NOTE: the one-cycle strobes default low here and are raised only by
         // the transition that owns them, so each lasts exactly one cycle.
         line_load <= '0;
         line_done <= 1'b0;
         // busy mirrors state != IDLE, so this flags any pulse that cannot start.
         overrun   <= hsync_start && busy;

         case (state)
            IDLE: begin
               if (hsync_start) begin
                  target <= {y[COORD_WIDTH-1], y} + TGT_W'(1);
                  idx    <= '0;
                  abort  <= 1'b0;
                  busy   <= 1'b1;
                  state  <= SCAN;
               end
            end

            SCAN: begin
               if (vsync_start) begin
                  line_done <= 1'b1;
                  state     <= DONE;
               end else if (hit) begin
                  mem_req  <= 1'b1;
                  mem_addr <= cur_base + row;
                  state    <= REQUEST;
               end else if (last_idx) begin
                  line_done <= 1'b1;
                  state     <= DONE;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end

            REQUEST: begin
               if (mem_ack) begin
                  // Request drops on the ack edge; LOAD/DONE never re-request,
                  // so there is always a gap cycle before the next mem_req.
                  mem_req   <= 1'b0;
                  line_data <= mem_rdata;
                  if (abort || vsync_start) begin
                     line_done <= 1'b1;
                     state     <= DONE;
                  end else begin
                     line_load <= NUM_SPRITES'(1) << idx;
                     state     <= LOAD;
                  end
               end else if (vsync_start) begin
                  // The handshake cannot be withdrawn; remember to skip LOAD.
                  abort <= 1'b1;
               end
            end

            LOAD: begin
               if (last_idx) begin
                  line_done <= 1'b1;
                  state     <= DONE;
               end else begin
                  idx   <= idx + IDX_W'(1);
                  state <= SCAN;
               end
            end

            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               busy    <= 1'b0;
               mem_req <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sprite_fetch_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sprite_fetch_scheduler
//
// Directed bench for sprite_fetch_scheduler with default parameters
// (16-bit coordinates, 4 slots, 16-bit address/data, 16-line sprites).
// Inputs change 1 time unit after a rising edge; outputs are observed at the
// same point, well clear of the edge. Cycle comments use T for the cycle in
// which hsync_start is high; the scan's first SCAN cycle is T+1.
// The line a scan targets is y+1, so a sprite at sprite_y covers targets
// sprite_y .. sprite_y+15, i.e. y values sprite_y-1 .. sprite_y+14.
// -----------------------------------------------------------------------------
module tb_sprite_fetch_scheduler;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        hsync_start = 1'b0;
   logic        vsync_start = 1'b0;
   logic [15:0] y = '0;
   logic [3:0]  sprite_enable = '0;
   logic [63:0] sprite_y = '0;
   logic [63:0] sprite_base_addr = '0;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [15:0] mem_rdata = '0;
   logic [15:0] line_data;
   logic [3:0]  line_load;
   logic        busy;
   logic        line_done;
   logic        overrun;

   int checks = 0;
   int errors = 0;

   // Event counters, sampled on the falling edge.
   int   req_rises = 0;
   int   load_cnt  = 0;
   int   done_cnt  = 0;
   logic req_prev  = 1'b0;

   sprite_fetch_scheduler dut (
      .pixel_clock      (clk),
      .reset_n          (reset_n),
      .hsync_start      (hsync_start),
      .vsync_start      (vsync_start),
      .y                (y),
      .sprite_enable    (sprite_enable),
      .sprite_y         (sprite_y),
      .sprite_base_addr (sprite_base_addr),
      .mem_req          (mem_req),
      .mem_addr         (mem_addr),
      .mem_ack          (mem_ack),
      .mem_rdata        (mem_rdata),
      .line_data        (line_data),
      .line_load        (line_load),
      .busy             (busy),
      .line_done        (line_done),
      .overrun          (overrun)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      req_prev <= mem_req;
      if (mem_req && !req_prev) req_rises <= req_rises + 1;
      if (line_load != 4'b0000) load_cnt <= load_cnt + 1;
      if (line_done) done_cnt <= done_cnt + 1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_slot(input int i, input logic [15:0] sy, input logic [15:0] base);
      sprite_y[i*16 +: 16]         = sy;
      sprite_base_addr[i*16 +: 16] = base;
   endtask

   // Holds hsync_start for one edge; returns in cycle T+1.
   task automatic pulse_hsync();
      hsync_start = 1'b1;
      step();
      hsync_start = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_mem_req"},   mem_req,   1'b0);
      check({tag, "_mem_addr"},  mem_addr,  16'h0000);
      check({tag, "_line_data"}, line_data, 16'h0000);
      check({tag, "_line_load"}, line_load, 4'b0000);
      check({tag, "_busy"},      busy,      1'b0);
      check({tag, "_line_done"}, line_done, 1'b0);
      check({tag, "_overrun"},   overrun,   1'b0);
   endtask

   // Full scan with only slot 0 enabled and a zero-wait ack on a hit.
   // Hit: REQUEST T+2, LOAD T+3, SCAN idx1..3 T+4..T+6, DONE T+7.
   // Miss: SCAN idx0..3 T+1..T+4, DONE T+5.
   task automatic run_one_slot(input string tag, input logic [15:0] yy, input logic [15:0] sy,
                               input logic [15:0] base, input bit expect_hit,
                               input logic [15:0] expect_addr);
      int l0;
      l0 = load_cnt;
      sprite_enable = 4'b0001;
      set_slot(0, sy, base);
      y = yy;
      pulse_hsync();                                   // T+1
      check({tag, "_busy_start"}, busy, 1'b1);
      step();                                          // T+2
      if (expect_hit) begin
         check({tag, "_req"},  mem_req,  1'b1);
         check({tag, "_addr"}, mem_addr, expect_addr);
         mem_ack   = 1'b1;
         mem_rdata = expect_addr ^ 16'h5A5A;
         step();                                       // T+3
         mem_ack = 1'b0;
         check({tag, "_load"}, line_load, 4'b0001);
         check({tag, "_data"}, line_data, expect_addr ^ 16'h5A5A);
         repeat (4) step();                            // T+7
      end else begin
         check({tag, "_noreq"}, mem_req, 1'b0);
         repeat (3) step();                            // T+5
         check({tag, "_noload"}, load_cnt - l0, 0);
      end
      check({tag, "_done"}, line_done, 1'b1);
      step();
      check({tag, "_idle"}, busy, 1'b0);
   endtask

   initial begin
      int          r0;
      int          l0;
      int          d0;
      logic [15:0] exp_addr [4];
      logic [3:0]  onehot;

      // ---------------- reset state ----------------
      reset_n = 1'b0;
      step();
      step();
      check_all_zero("reset");
      reset_n = 1'b1;
      repeat (3) step();
      check("post_reset_no_req",  mem_req, 1'b0);
      check("post_reset_no_busy", busy,    1'b0);

      // ---------------- no hits: y=5, all disabled ----------------
      // Slots would hit if enabled, so the enable gate is what matters.
      for (int i = 0; i < 4; i++) set_slot(i, 16'd0, 16'h0100);
      sprite_enable = 4'b0000;
      y  = 16'd5;
      r0 = req_rises;
      l0 = load_cnt;
      d0 = done_cnt;
      pulse_hsync();                                   // T+1
      check("nohit_busy", busy, 1'b1);
      repeat (3) step();                               // T+4
      check("nohit_not_done_early", line_done, 1'b0);
      step();                                          // T+5
      check("nohit_done", line_done, 1'b1);
      step();                                          // T+6
      check("nohit_done_pulse", line_done, 1'b0);
      check("nohit_idle", busy, 1'b0);
      check("nohit_req_count",  req_rises - r0, 0);
      check("nohit_load_count", load_cnt - l0, 0);
      check("nohit_done_count", done_cnt - d0, 1);

      // ---------------- single hit in slot 2, ack 3 cycles late ----------------
      // target=6, row 6 -> 0x0100+6 = 0x0106.
      sprite_enable = 4'b0100;
      set_slot(2, 16'd0, 16'h0100);
      y = 16'd5;
      pulse_hsync();                                   // T+1 SCAN idx0
      step();
      step();                                          // T+3 SCAN idx2 (hit)
      check("single_req_low_in_scan", mem_req, 1'b0);
      step();                                          // T+4 REQUEST
      check("single_req", mem_req, 1'b1);
      check("single_addr", mem_addr, 16'h0106);
      step();
      step();                                          // T+6
      check("single_req_held", mem_req, 1'b1);
      check("single_addr_held", mem_addr, 16'h0106);
      step();                                          // T+7
      mem_ack   = 1'b1;
      mem_rdata = 16'hBEEF;
      step();                                          // T+8 LOAD
      mem_ack   = 1'b0;
      mem_rdata = 16'h0000;
      check("single_req_dropped", mem_req, 1'b0);
      check("single_load", line_load, 4'b0100);
      check("single_data", line_data, 16'hBEEF);
      step();                                          // T+9 SCAN idx3
      check("single_load_pulse", line_load, 4'b0000);
      check("single_not_done", line_done, 1'b0);
      step();                                          // T+10 DONE
      check("single_done", line_done, 1'b1);
      step();

      // ---------------- all four slots hit, zero-wait acks ----------------
      // y=9 -> target 10; rows 10,8,6,4.
      sprite_enable = 4'b1111;
      set_slot(0, 16'd0, 16'h1000);
      set_slot(1, 16'd2, 16'h2000);
      set_slot(2, 16'd4, 16'h3000);
      set_slot(3, 16'd6, 16'h4000);
      exp_addr[0] = 16'h100A;
      exp_addr[1] = 16'h2008;
      exp_addr[2] = 16'h3006;
      exp_addr[3] = 16'h4004;
      y  = 16'd9;
      r0 = req_rises;
      pulse_hsync();                                   // T+1
      for (int k = 0; k < 4; k++) begin
         onehot = 4'b0001 << k;
         check($sformatf("all_scan_noreq_%0d", k), mem_req, 1'b0);
         step();                                       // T+2+3k REQUEST
         check($sformatf("all_req_%0d", k),  mem_req,  1'b1);
         check($sformatf("all_addr_%0d", k), mem_addr, exp_addr[k]);
         mem_ack   = 1'b1;
         mem_rdata = 16'hA000 + 16'(k);
         step();                                       // T+3+3k LOAD
         mem_ack = 1'b0;
         check($sformatf("all_gap_%0d", k),  mem_req,   1'b0);
         check($sformatf("all_load_%0d", k), line_load, onehot);
         check($sformatf("all_data_%0d", k), line_data, 16'hA000 + 16'(k));
         step();                                       // T+4+3k
      end
      check("all_done_t13", line_done, 1'b1);
      check("all_req_count", req_rises - r0, 4);
      step();
      check("all_idle", busy, 1'b0);

      // ---------------- boundary rows ----------------
      run_one_slot("top_row",      -16'sd4, -16'sd3, 16'h0200, 1'b1, 16'h0200);
      run_one_slot("above_sprite", -16'sd5, -16'sd3, 16'h0200, 1'b0, 16'h0000);
      run_one_slot("bottom_row",    16'd24,  16'd10, 16'h0300, 1'b1, 16'h030F);
      run_one_slot("below_sprite",  16'd25,  16'd10, 16'h0300, 1'b0, 16'h0000);

      // ---------------- overrun ----------------
      sprite_enable = 4'b0000;
      y  = 16'd5;
      d0 = done_cnt;
      pulse_hsync();                                   // T+1
      step();                                          // T+2
      hsync_start = 1'b1;
      step();                                          // T+3
      hsync_start = 1'b0;
      check("overrun_pulse", overrun, 1'b1);
      step();                                          // T+4
      check("overrun_one_cycle", overrun, 1'b0);
      step();                                          // T+5
      check("overrun_done_on_time", line_done, 1'b1);
      repeat (4) step();
      check("overrun_single_done", done_cnt - d0, 1);
      check("overrun_idle", busy, 1'b0);

      // ---------------- vsync in SCAN ----------------
      sprite_enable = 4'b0000;
      pulse_hsync();                                   // T+1
      step();                                          // T+2
      vsync_start = 1'b1;
      step();                                          // T+3
      vsync_start = 1'b0;
      check("vscan_done_early", line_done, 1'b1);
      step();
      check("vscan_idle", busy, 1'b0);

      // ---------------- vsync in REQUEST ----------------
      // y=0 -> target 1, row 1 -> 0x0401.
      sprite_enable = 4'b0001;
      set_slot(0, 16'd0, 16'h0400);
      y  = 16'd0;
      l0 = load_cnt;
      pulse_hsync();                                   // T+1
      step();                                          // T+2 REQUEST
      check("vreq_req", mem_req, 1'b1);
      vsync_start = 1'b1;
      step();                                          // T+3
      vsync_start = 1'b0;
      check("vreq_req_held", mem_req, 1'b1);
      check("vreq_addr_held", mem_addr, 16'h0401);
      step();                                          // T+4
      mem_ack   = 1'b1;
      mem_rdata = 16'hCAFE;
      step();                                          // T+5
      mem_ack = 1'b0;
      check("vreq_req_dropped", mem_req, 1'b0);
      check("vreq_done", line_done, 1'b1);
      check("vreq_no_load", load_cnt - l0, 0);
      step();
      check("vreq_idle", busy, 1'b0);

      // ---------------- hsync and vsync together while idle ----------------
      sprite_enable = 4'b0000;
      vsync_start   = 1'b1;
      pulse_hsync();                                   // T+1
      vsync_start = 1'b0;
      check("hv_start_busy", busy, 1'b1);
      repeat (3) step();                               // T+4
      check("hv_not_done_early", line_done, 1'b0);
      step();                                          // T+5
      check("hv_done", line_done, 1'b1);
      step();

      // ---------------- reset while mem_req is high ----------------
      sprite_enable = 4'b0001;
      set_slot(0, 16'd0, 16'h0500);
      y = 16'd0;
      pulse_hsync();                                   // T+1
      step();                                          // T+2 REQUEST
      check("rst_mid_req_high", mem_req, 1'b1);
      reset_n = 1'b0;
      step();
      check_all_zero("rst_mid");
      reset_n = 1'b1;
      repeat (3) step();
      check("rst_mid_no_req_after", mem_req, 1'b0);
      run_one_slot("after_reset", 16'd3, 16'd0, 16'h0600, 1'b1, 16'h0604);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
